// File: rtl/video_timing_gen.sv
// Video timing and lag-measurement flash pattern source: free-running h/v counters,
// region decode and a registered pixel stream feeding the TMDS encoders.
module video_timing_gen #(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter bit          HSYNC_POL    = 1'b0,
  parameter bit          VSYNC_POL    = 1'b0,
  parameter int          BOX_X0       = 256,
  parameter int          BOX_Y0       = 176,
  parameter int          BOX_W        = 128,
  parameter int          BOX_H        = 128,
  parameter int          FLASH_FRAMES = 30,
  parameter logic [7:0]  GREY         = 8'h40
) (
  input  logic        clk,
  input  logic        rst,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start,
  output logic        flash_trig
);

  localparam int FC_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT_END = 12'(V_ACTIVE);
  localparam logic [11:0] VS_START  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST    = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] BX0       = 12'(BOX_X0);
  localparam logic [11:0] BX1       = 12'(BOX_X0 + BOX_W);
  localparam logic [11:0] BY0       = 12'(BOX_Y0);
  localparam logic [11:0] BY1       = 12'(BOX_Y0 + BOX_H);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLASH_FRAMES - 1);

  logic [11:0]     h_cnt, v_cnt;
  logic [FC_W-1:0] frame_cnt;
  logic            flash_on;

  logic       active, hs_act, vs_act, in_box, at_origin;
  logic [7:0] pix;

  // Phase state moves on the same edge the counters return to (0,0), so a
  // whole frame always sees a single flash phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
      flash_on  <= 1'b0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt <= '0;
        if (frame_cnt == FC_LAST) begin
          frame_cnt <= '0;
          flash_on  <= ~flash_on;
        end else begin
          frame_cnt <= frame_cnt + FC_W'(1);
        end
      end else begin
        v_cnt <= v_cnt + 12'd1;
      end
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  always_comb begin
    active    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hs_act    = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_act    = (v_cnt >= VS_START) && (v_cnt < VS_END);
    in_box    = (h_cnt >= BX0) && (h_cnt < BX1) && (v_cnt >= BY0) && (v_cnt < BY1);
    at_origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    pix       = 8'h00;
    if (active) pix = in_box ? {8{flash_on}} : GREY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de          <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      red         <= 8'h00;
      green       <= 8'h00;
      blue        <= 8'h00;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      flash_trig  <= 1'b0;
    end else begin
      de          <= active;
      hsync       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      red         <= pix;
      green       <= pix;
      blue        <= pix;
      x           <= h_cnt;
      y           <= v_cnt;
      frame_start <= at_origin;
      // frame_cnt == 0 with flash_on set is only true on the first white frame
      flash_trig  <= at_origin && flash_on && (frame_cnt == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using the small 14x7 timing, box (2,1) 3x2,
// two-frame flash phases; a second instance checks inverted sync polarity.
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        de, hs, vs, fs, ft;
  logic [7:0]  r, g, b;
  logic [11:0] x, y;
  logic        p_de, p_hs, p_vs, p_fs, p_ft;
  logic [7:0]  p_r, p_g, p_b;
  logic [11:0] p_x, p_y;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .BOX_X0(2), .BOX_Y0(1), .BOX_W(3), .BOX_H(2),
    .FLASH_FRAMES(2), .GREY(8'h40)
  ) dut (
    .clk(clk), .rst(rst), .de(de), .hsync(hs), .vsync(vs),
    .red(r), .green(g), .blue(b), .x(x), .y(y),
    .frame_start(fs), .flash_trig(ft)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .BOX_X0(2), .BOX_Y0(1), .BOX_W(3), .BOX_H(2),
    .FLASH_FRAMES(2), .GREY(8'h40)
  ) dut_pol (
    .clk(clk), .rst(rst), .de(p_de), .hsync(p_hs), .vsync(p_vs),
    .red(p_r), .green(p_g), .blue(p_b), .x(p_x), .y(p_y),
    .frame_start(p_fs), .flash_trig(p_ft)
  );

  // Packed order: de hs vs r g b x y fs ft p_hs p_vs
  localparam logic [57:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00,
                                       12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic test_reset();
    logic [57:0] obs;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      obs = {de, hs, vs, r, g, b, x, y, fs, ft, p_hs, p_vs};
      vectors++;
      if (obs !== RESET_VEC) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs, RESET_VEC);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_first_pixel();
    logic [57:0] obs, exp_v;
    @(negedge clk);
    obs   = {de, hs, vs, r, g, b, x, y, fs, ft, p_hs, p_vs};
    exp_v = {1'b1, 1'b1, 1'b1, 8'h40, 8'h40, 8'h40, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL first_pixel: got %h expected %h", obs, exp_v);
    end
  endtask

  // Twelve frames starting at pixel index 1, each pixel against the hand-derived
  // timing: x = n%14, y = (n/14)%7, frame = n/98, white iff (frame/2) odd.
  task automatic test_frames();
    int ex, ey, fr, de_cnt, last_fs, trig_cnt;
    logic e_de, e_hs, e_vs, e_fs, e_ft, white, inb;
    logic [7:0] e_pix;
    de_cnt = 1; last_fs = 0; trig_cnt = 0;
    for (int n = 1; n < 1176; n++) begin
      @(negedge clk);
      ex    = n % 14;
      ey    = (n / 14) % 7;
      fr    = n / 98;
      white = ((fr / 2) % 2) == 1;
      e_de  = (ex < 8) && (ey < 4);
      e_hs  = (ex == 10) || (ex == 11);
      e_vs  = (ey == 5);
      inb   = (ex >= 2) && (ex < 5) && (ey >= 1) && (ey < 3);
      e_pix = !e_de ? 8'h00 : (inb ? (white ? 8'hFF : 8'h00) : 8'h40);
      e_fs  = (ex == 0) && (ey == 0);
      e_ft  = e_fs && ((fr % 4) == 2);
      vectors++;
      if ({x, y} !== {12'(ex), 12'(ey)}) begin
        errors++;
        $display("FAIL position n=%0d: got x=%0d y=%0d expected x=%0d y=%0d", n, x, y, ex, ey);
      end
      vectors++;
      if (de !== e_de) begin
        errors++;
        $display("FAIL de n=%0d: got %b expected %b", n, de, e_de);
      end
      vectors++;
      if ({hs, vs} !== {~e_hs, ~e_vs}) begin
        errors++;
        $display("FAIL sync_low n=%0d: got hs=%b vs=%b expected hs=%b vs=%b", n, hs, vs, ~e_hs, ~e_vs);
      end
      vectors++;
      if ({p_hs, p_vs} !== {e_hs, e_vs}) begin
        errors++;
        $display("FAIL sync_high n=%0d: got hs=%b vs=%b expected hs=%b vs=%b", n, p_hs, p_vs, e_hs, e_vs);
      end
      vectors++;
      if ({r, g, b} !== {e_pix, e_pix, e_pix}) begin
        errors++;
        $display("FAIL rgb n=%0d (x=%0d y=%0d frame=%0d): got %h/%h/%h expected %h", n, ex, ey, fr, r, g, b, e_pix);
      end
      vectors++;
      if ({fs, ft} !== {e_fs, e_ft}) begin
        errors++;
        $display("FAIL pulses n=%0d: got fs=%b ft=%b expected fs=%b ft=%b", n, fs, ft, e_fs, e_ft);
      end
      if (de === 1'b1) de_cnt++;
      if (ft === 1'b1) trig_cnt++;
      if (fs === 1'b1) begin
        vectors++;
        if (n - last_fs !== 98) begin
          errors++;
          $display("FAIL frame_period n=%0d: got %0d clocks expected 98", n, n - last_fs);
        end
        last_fs = n;
      end
      if ((n % 98) == 97) begin
        vectors++;
        if (de_cnt !== 32) begin
          errors++;
          $display("FAIL de_per_frame frame=%0d: got %0d expected 32", fr, de_cnt);
        end
        de_cnt = 0;
      end
    end
    vectors++;
    if (trig_cnt !== 3) begin
      errors++;
      $display("FAIL trig_count: got %0d expected 3", trig_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [57:0] obs;
    logic [7:0]  e_box;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    // Pixel index 327 = frame 3, y=2, x=5
    for (int n = 0; n <= 327; n++) @(negedge clk);
    vectors++;
    if ({de, x, y} !== {1'b1, 12'd5, 12'd2}) begin
      errors++;
      $display("FAIL pre_reset_pixel: got de=%b x=%0d y=%0d expected de=1 x=5 y=2", de, x, y);
    end
    rst = 1'b1;
    #1;
    obs = {de, hs, vs, r, g, b, x, y, fs, ft, p_hs, p_vs};
    vectors++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL async_clear: got %h expected %h", obs, RESET_VEC);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      vectors++;
      if ({fs, ft} !== {((n % 98) == 0), (n == 196)}) begin
        errors++;
        $display("FAIL restart_pulses n=%0d: got fs=%b ft=%b", n, fs, ft);
      end
      if ((n % 98) == 16) begin
        e_box = (n >= 196) ? 8'hFF : 8'h00;
        vectors++;
        if ({x, y, r, g, b} !== {12'd2, 12'd1, e_box, e_box, e_box}) begin
          errors++;
          $display("FAIL restart_box n=%0d: got x=%0d y=%0d rgb=%h/%h/%h expected (2,1) %h", n, x, y, r, g, b, e_box);
        end
      end
      if ((n % 98) == 15) begin
        vectors++;
        if ({x, y, r, g, b} !== {12'd1, 12'd1, 8'h40, 8'h40, 8'h40}) begin
          errors++;
          $display("FAIL restart_grey n=%0d: got x=%0d y=%0d rgb=%h/%h/%h expected (1,1) 40", n, x, y, r, g, b);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_frames();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
